// File: rtl/kvs_query_ctrl.sv
// ---------------------------------------------------------------------------
// kvs_query_ctrl
//
// Initiator side of the KVS lookup interface; db_top answers on the other
// side. Parsed flow keys come in from the Ethernet parser over a valid/ready
// handshake and are forwarded to the database as one-cycle lookup strobes.
// Every accepted key leaves an entry {flag, accept tick} in an in-order
// outstanding FIFO. Database responses arrive strictly in request order and
// are matched against the FIFO head. When the head waits too long, a timeout
// verdict is emitted instead. The database's eventual late answer is then
// swallowed through the skip counter. Runs entirely in the db_clk domain.
//
// Ports
//   clk             db_clk, the only clock
//   rst             synchronous, active-high reset
//   req_key         flow key from the parser
//   req_flag        request flag, forwarded to the DB and returned with verdict
//   req_valid       parser key valid
//   req_ready       key accepted when req_valid & req_ready
//   in_key          lookup key to the DB
//   in_flag         lookup flag to the DB
//   in_valid        one-cycle lookup strobe to the DB
//   out_valid       DB response strobe, in request order
//   out_flag        DB response flag, bit 0 = hit
//   verdict_valid   one-cycle verdict strobe, consumer never stalls
//   verdict_hit     out_flag[0] of the matched response, 0 on timeout
//   verdict_timeout verdict produced by timeout
//   verdict_flag    req_flag of the matched request
//   err_spurious    sticky: a response arrived with nothing outstanding
// ---------------------------------------------------------------------------
module kvs_query_ctrl #(
  parameter int KEY_SIZE  = 96,
  parameter int FLAG_W    = 4,
  parameter int MAX_OUTST = 8,
  parameter int TIMEOUT   = 1024
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [KEY_SIZE-1:0] req_key,
  input  logic [FLAG_W-1:0]   req_flag,
  input  logic                req_valid,
  output logic                req_ready,
  output logic [KEY_SIZE-1:0] in_key,
  output logic [FLAG_W-1:0]   in_flag,
  output logic                in_valid,
  input  logic                out_valid,
  input  logic [FLAG_W-1:0]   out_flag,
  output logic                verdict_valid,
  output logic                verdict_hit,
  output logic                verdict_timeout,
  output logic [FLAG_W-1:0]   verdict_flag,
  output logic                err_spurious
);

  localparam int PTR_W = $clog2(MAX_OUTST);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W:0] MAX_SUM     = (CNT_W + 1)'(MAX_OUTST);
  localparam logic [15:0]    TIMEOUT_AGE = 16'(TIMEOUT);

  // Free-running timestamp counter
  logic [15:0] tick_q, tick_d;

  // Outstanding-request FIFO
  logic [FLAG_W-1:0] flag_mem_q [MAX_OUTST];
  logic [FLAG_W-1:0] flag_mem_d [MAX_OUTST];
  logic [15:0]       ts_mem_q   [MAX_OUTST];
  logic [15:0]       ts_mem_d   [MAX_OUTST];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  fifo_cnt_q, fifo_cnt_d;

  // Late responses still owed by the DB for requests that already timed out
  logic [CNT_W-1:0]  skip_cnt_q, skip_cnt_d;

  logic              req_ready_q, req_ready_d;

  // Lookup and verdict output registers
  logic [KEY_SIZE-1:0] in_key_q, in_key_d;
  logic [FLAG_W-1:0]   in_flag_q, in_flag_d;
  logic                in_valid_q, in_valid_d;
  logic                verdict_valid_q, verdict_valid_d;
  logic                verdict_hit_q, verdict_hit_d;
  logic                verdict_timeout_q, verdict_timeout_d;
  logic [FLAG_W-1:0]   verdict_flag_q, verdict_flag_d;
  logic                err_spurious_q, err_spurious_d;

  // Per-cycle events
  logic              accept;
  logic              fifo_empty;
  logic              resp_skip;
  logic              resp_pop;
  logic              resp_spurious;
  logic              timeout_pop;
  logic              pop;
  logic [15:0]       head_age;
  logic [CNT_W:0]    load_sum;

  // Classify this cycle's events. A response first pays off any owed skip.
  // Otherwise it matches the FIFO head. With nothing outstanding it is
  // spurious. The timeout looks at the head as it stands this cycle and
  // yields to a popping response; modulo-2^16 age keeps tick wrap harmless.
  always_comb begin
    accept        = req_valid & req_ready_q;
    fifo_empty    = (fifo_cnt_q == '0);
    resp_skip     = out_valid & (skip_cnt_q != '0);
    resp_pop      = out_valid & (skip_cnt_q == '0) & ~fifo_empty;
    resp_spurious = out_valid & (skip_cnt_q == '0) & fifo_empty;
    head_age      = tick_q - ts_mem_q[rd_ptr_q];
    timeout_pop   = ~fifo_empty & (head_age >= TIMEOUT_AGE) & ~resp_pop;
    pop           = resp_pop | timeout_pop;
  end

  // FIFO bookkeeping: push on accept, pop on a matched response or timeout.
  // Both may happen in one cycle, leaving the occupancy unchanged.
  always_comb begin
    flag_mem_d = flag_mem_q;
    ts_mem_d   = ts_mem_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    if (accept) begin
      flag_mem_d[wr_ptr_q] = req_flag;
      ts_mem_d[wr_ptr_q]   = tick_q;
      wr_ptr_d             = wr_ptr_q + PTR_W'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
    fifo_cnt_d = fifo_cnt_q + CNT_W'(accept) - CNT_W'(pop);
    skip_cnt_d = skip_cnt_q - CNT_W'(resp_skip) + CNT_W'(timeout_pop);
    tick_d     = tick_q + 16'd1;
  end

  // Ready is registered but computed from next-cycle occupancy, so it
  // drops right after the last free slot is taken and rises the cycle
  // after a pop or a skip discard frees one.
  always_comb begin
    load_sum    = {1'b0, fifo_cnt_d} + {1'b0, skip_cnt_d};
    req_ready_d = (load_sum < MAX_SUM);
  end

  // Lookup strobe toward the DB, one cycle after the accept
  always_comb begin
    in_valid_d = accept;
    in_key_d   = accept ? req_key  : in_key_q;
    in_flag_d  = accept ? req_flag : in_flag_q;
  end

  // Verdict for whichever pop happened this cycle; at most one can happen.
  // The spurious flag is sticky until reset.
  always_comb begin
    verdict_valid_d   = pop;
    verdict_hit_d     = resp_pop & out_flag[0];
    verdict_timeout_d = timeout_pop;
    verdict_flag_d    = pop ? flag_mem_q[rd_ptr_q] : '0;
    err_spurious_d    = err_spurious_q | resp_spurious;
  end

  // State registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      tick_q            <= '0;
      for (int i = 0; i < MAX_OUTST; i++) begin
        flag_mem_q[i] <= '0;
        ts_mem_q[i]   <= '0;
      end
      wr_ptr_q          <= '0;
      rd_ptr_q          <= '0;
      fifo_cnt_q        <= '0;
      skip_cnt_q        <= '0;
      req_ready_q       <= 1'b0;
      in_key_q          <= '0;
      in_flag_q         <= '0;
      in_valid_q        <= 1'b0;
      verdict_valid_q   <= 1'b0;
      verdict_hit_q     <= 1'b0;
      verdict_timeout_q <= 1'b0;
      verdict_flag_q    <= '0;
      err_spurious_q    <= 1'b0;
    end else begin
      tick_q            <= tick_d;
      flag_mem_q        <= flag_mem_d;
      ts_mem_q          <= ts_mem_d;
      wr_ptr_q          <= wr_ptr_d;
      rd_ptr_q          <= rd_ptr_d;
      fifo_cnt_q        <= fifo_cnt_d;
      skip_cnt_q        <= skip_cnt_d;
      req_ready_q       <= req_ready_d;
      in_key_q          <= in_key_d;
      in_flag_q         <= in_flag_d;
      in_valid_q        <= in_valid_d;
      verdict_valid_q   <= verdict_valid_d;
      verdict_hit_q     <= verdict_hit_d;
      verdict_timeout_q <= verdict_timeout_d;
      verdict_flag_q    <= verdict_flag_d;
      err_spurious_q    <= err_spurious_d;
    end
  end

  assign req_ready       = req_ready_q;
  assign in_key          = in_key_q;
  assign in_flag         = in_flag_q;
  assign in_valid        = in_valid_q;
  assign verdict_valid   = verdict_valid_q;
  assign verdict_hit     = verdict_hit_q;
  assign verdict_timeout = verdict_timeout_q;
  assign verdict_flag    = verdict_flag_q;
  assign err_spurious    = err_spurious_q;

endmodule

// File: tb/tb_kvs_query_ctrl.sv
// ---------------------------------------------------------------------------
// tb_kvs_query_ctrl
//
// Drives kvs_query_ctrl with directed scenarios followed by randomized
// traffic. A transaction-level reference model (queue of outstanding
// requests with accept cycle numbers, owed-skip count, sticky error flag)
// predicts lookups and verdicts. Predictions are queued with the cycle they
// are due, and a separate negedge monitor compares them with the DUT outputs.
// ---------------------------------------------------------------------------
module tb_kvs_query_ctrl;

  localparam int KEY_W     = 96;
  localparam int FLAG_W    = 4;
  localparam int MAX_OUTST = 8;
  localparam int TIMEOUT   = 16;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [KEY_W-1:0]  req_key = '0;
  logic [FLAG_W-1:0] req_flag = '0;
  logic              req_valid = 1'b0;
  logic              req_ready;
  logic [KEY_W-1:0]  in_key;
  logic [FLAG_W-1:0] in_flag;
  logic              in_valid;
  logic              out_valid = 1'b0;
  logic [FLAG_W-1:0] out_flag = '0;
  logic              verdict_valid;
  logic              verdict_hit;
  logic              verdict_timeout;
  logic [FLAG_W-1:0] verdict_flag;
  logic              err_spurious;

  kvs_query_ctrl #(
    .KEY_SIZE (KEY_W),
    .FLAG_W   (FLAG_W),
    .MAX_OUTST(MAX_OUTST),
    .TIMEOUT  (TIMEOUT)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .req_key        (req_key),
    .req_flag       (req_flag),
    .req_valid      (req_valid),
    .req_ready      (req_ready),
    .in_key         (in_key),
    .in_flag        (in_flag),
    .in_valid       (in_valid),
    .out_valid      (out_valid),
    .out_flag       (out_flag),
    .verdict_valid  (verdict_valid),
    .verdict_hit    (verdict_hit),
    .verdict_timeout(verdict_timeout),
    .verdict_flag   (verdict_flag),
    .err_spurious   (err_spurious)
  );

  always #5 clk = ~clk;

  typedef struct {
    int                ts;
    logic [FLAG_W-1:0] flag;
  } reqT;

  typedef struct {
    int                cyc;
    logic              hit;
    logic              tmo;
    logic [FLAG_W-1:0] flag;
  } verdictT;

  typedef struct {
    int                cyc;
    logic [KEY_W-1:0]  key;
    logic [FLAG_W-1:0] flag;
  } lookupT;

  reqT     outstQ[$];
  verdictT expVerdictQ[$];
  lookupT  expLookupQ[$];
  int      skipCount   = 0;
  bit      modelReady  = 1'b0;
  bit      modelErr    = 1'b0;
  bit      justReset   = 1'b0;
  bit      monitorOn   = 1'b0;
  int      cycleNo     = 0;
  int      compared    = 0;
  int      mismatched  = 0;

  // Single comparison primitive shared by driver and monitor
  task automatic checkOutput(input string name, input logic [127:0] actual,
                             input logic [127:0] expected);
    compared++;
    if (actual !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0h, expected %0h (cycle %0d)",
               name, actual, expected, cycleNo);
    end
  endtask

  // Monitor: every cycle, compare the strobes with what the model says is
  // due in this cycle, and the payloads when a strobe is due.
  task automatic monitorCycle();
    verdictT ev;
    lookupT  el;
    bit      expV;
    bit      expL;
    expV = (expVerdictQ.size() > 0) && (expVerdictQ[0].cyc == cycleNo);
    checkOutput("verdictValid", 128'(verdict_valid), 128'(expV));
    if (expV) begin
      ev = expVerdictQ.pop_front();
      if (verdict_valid) begin
        checkOutput("verdictHit", 128'(verdict_hit), 128'(ev.hit));
        checkOutput("verdictTimeout", 128'(verdict_timeout), 128'(ev.tmo));
        checkOutput("verdictFlag", 128'(verdict_flag), 128'(ev.flag));
      end
    end
    expL = (expLookupQ.size() > 0) && (expLookupQ[0].cyc == cycleNo);
    checkOutput("inValid", 128'(in_valid), 128'(expL));
    if (expL) begin
      el = expLookupQ.pop_front();
      if (in_valid) begin
        checkOutput("inKey", 128'(in_key), 128'(el.key));
        checkOutput("inFlag", 128'(in_flag), 128'(el.flag));
      end
    end
  endtask

  always @(negedge clk) begin
    if (monitorOn) monitorCycle();
  end

  // One clock cycle: check level outputs, drive inputs, advance the model
  // across the coming edge, then return 1 time unit after the next negedge.
  task automatic applyStimulus(input bit doReset, input bit reqValid,
                               input logic [KEY_W-1:0] key,
                               input logic [FLAG_W-1:0] flag,
                               input bit respValid,
                               input logic [FLAG_W-1:0] respFlag);
    reqT head;
    bit  popped;
    if (monitorOn) begin
      checkOutput("reqReady", 128'(req_ready), 128'(modelReady));
      checkOutput("errSpurious", 128'(err_spurious), 128'(modelErr));
      if (justReset) begin
        checkOutput("resetOutputs",
                    128'({in_valid, in_key, in_flag, verdict_valid,
                          verdict_hit, verdict_timeout, verdict_flag}),
                    128'(0));
      end
    end
    justReset = 1'b0;
    rst       = doReset;
    req_valid = reqValid;
    req_key   = key;
    req_flag  = flag;
    out_valid = respValid;
    out_flag  = respFlag;
    if (doReset) begin
      outstQ.delete();
      expVerdictQ.delete();
      expLookupQ.delete();
      skipCount  = 0;
      modelReady = 1'b0;
      modelErr   = 1'b0;
      justReset  = 1'b1;
    end else begin
      popped = 1'b0;
      if (respValid) begin
        if (skipCount > 0) begin
          skipCount--;
        end else if (outstQ.size() > 0) begin
          head = outstQ.pop_front();
          expVerdictQ.push_back('{cycleNo + 1, respFlag[0], 1'b0, head.flag});
          popped = 1'b1;
        end else begin
          modelErr = 1'b1;
        end
      end
      if (!popped && outstQ.size() > 0 && (cycleNo - outstQ[0].ts) >= TIMEOUT) begin
        head = outstQ.pop_front();
        skipCount++;
        expVerdictQ.push_back('{cycleNo + 1, 1'b0, 1'b1, head.flag});
      end
      if (reqValid && modelReady) begin
        outstQ.push_back('{cycleNo, flag});
        expLookupQ.push_back('{cycleNo + 1, key, flag});
      end
      modelReady = (outstQ.size() + skipCount) < MAX_OUTST;
    end
    @(posedge clk);
    cycleNo++;
    @(negedge clk);
    #1;
    if (doReset) monitorOn = 1'b1;
  endtask

  task automatic idleCycles(input int n);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, 1'b0, '0, '0, 1'b0, '0);
  endtask

  task automatic sendReq(input logic [KEY_W-1:0] key, input logic [FLAG_W-1:0] flag);
    applyStimulus(1'b0, 1'b1, key, flag, 1'b0, '0);
  endtask

  task automatic sendResp(input logic [FLAG_W-1:0] respFlag);
    applyStimulus(1'b0, 1'b0, '0, '0, 1'b1, respFlag);
  endtask

  task automatic resetCycles(input int n);
    for (int i = 0; i < n; i++) applyStimulus(1'b1, 1'b0, '0, '0, 1'b0, '0);
  endtask

  initial begin
    logic [KEY_W-1:0] rndKey;
    int               respPct;
    @(negedge clk);
    #1;
    resetCycles(2);
    idleCycles(2);

    // Single hit lookup answered after 5 cycles
    sendReq(96'h1, 4'h2);
    idleCycles(4);
    sendResp(4'h1);
    idleCycles(3);

    // Fill all slots, try one more, then drain in order with mixed hits
    for (int i = 0; i < MAX_OUTST; i++) sendReq(96'(i + 100), 4'(i));
    sendReq(96'hDEAD, 4'hF);
    idleCycles(2);
    sendResp(4'h1);
    sendReq(96'hBEEF, 4'hA);
    for (int i = 0; i < MAX_OUTST; i++) sendResp(4'(i));
    idleCycles(3);

    // Timeout with no answer, followed by the late answer being discarded
    sendReq(96'h55, 4'h5);
    idleCycles(20);
    sendResp(4'h1);
    idleCycles(2);

    // Response in the very cycle the head reaches its timeout age
    sendReq(96'h77, 4'h7);
    idleCycles(TIMEOUT - 1);
    sendResp(4'h1);
    sendReq(96'h78, 4'h8);
    idleCycles(2);
    sendResp(4'h0);
    idleCycles(2);

    // Spurious response with nothing outstanding
    sendResp(4'h1);
    idleCycles(3);
    resetCycles(1);
    idleCycles(2);

    // Reset with three lookups outstanding; their answers become spurious
    sendReq(96'h1001, 4'h1);
    sendReq(96'h1002, 4'h2);
    sendReq(96'h1003, 4'h3);
    resetCycles(1);
    idleCycles(1);
    sendResp(4'h1);
    sendResp(4'h0);
    sendResp(4'h1);
    idleCycles(2);
    resetCycles(1);
    idleCycles(1);

    // Randomized traffic, alternating busy and sluggish DB phases
    for (int i = 0; i < 3000; i++) begin
      respPct = ((i / 400) % 2 == 0) ? 45 : 8;
      rndKey  = {$urandom(), $urandom(), $urandom()};
      applyStimulus($urandom_range(0, 699) == 0,
                    $urandom_range(0, 1) == 1,
                    rndKey,
                    4'($urandom_range(0, 15)),
                    $urandom_range(0, 99) < respPct,
                    4'($urandom_range(0, 15)));
    end

    idleCycles(80);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
